// File: rtl/serial_word_rx_if.sv
// Handshake bundle for serial_word_rx: qualified serial input, parallel word
// output with valid/ready, and sticky error flags with their clear strobe.
interface serial_word_rx_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             start;
    logic             s_in;
    logic             s_valid;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             busy;
    logic             overrun;
    logic             frame_err;
    logic             clr_err;

    // Producer/consumer side: drives the serial stream, takes the words.
    modport master (
        output enable,
        output start,
        output s_in,
        output s_valid,
        output data_ready,
        output clr_err,
        input  data_out,
        input  data_valid,
        input  busy,
        input  overrun,
        input  frame_err
    );

    // Receiver side.
    modport slave (
        input  enable,
        input  start,
        input  s_in,
        input  s_valid,
        input  data_ready,
        input  clr_err,
        output data_out,
        output data_valid,
        output busy,
        output overrun,
        output frame_err
    );
endinterface

// File: rtl/serial_word_rx.sv
// Double-buffered MSB-first serial-to-parallel receiver: a shift register
// assembles words while a holding register presents the last one via valid/ready.
module serial_word_rx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    serial_word_rx_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_busy;
    logic             r_overrun;
    logic             r_frame_err;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_word;
    logic             w_accept;
    logic             w_complete;
    logic             w_frame_evt;
    logic             w_drain;
    logic             w_load;
    logic             w_overrun_evt;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_valid_nxt;
    logic             w_overrun_nxt;
    logic             w_frame_nxt;

    assign w_accept = bus.enable & bus.s_valid;
    assign w_word   = {r_shreg[WIDTH-2:0], bus.s_in};

    // Receive FSM: next state, shift register and bit counter.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_complete  = 1'b0;
        w_frame_evt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && bus.start) begin
                    w_shreg_nxt = {{(WIDTH-1){1'b0}}, bus.s_in};
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = ST_RECV;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (w_accept && bus.start) begin
                    // A fresh start mid-word wins over completion of the old word.
                    w_shreg_nxt = {{(WIDTH-1){1'b0}}, bus.s_in};
                    w_cnt_nxt   = CNT_W'(1);
                    w_frame_evt = 1'b1;
                    w_state_nxt = ST_RECV;
                end else if (w_accept && (r_cnt == CNT_W'(WIDTH-1))) begin
                    w_complete  = 1'b1;
                    w_shreg_nxt = {WIDTH{1'b0}};
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_state_nxt = ST_IDLE;
                end else if (w_accept) begin
                    w_shreg_nxt = w_word;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end else begin
                    w_state_nxt = ST_RECV;
                end
            end
            default: begin
                w_shreg_nxt = {WIDTH{1'b0}};
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_drain       = r_valid & bus.data_ready;
    assign w_load        = w_complete & (~r_valid | w_drain);
    assign w_overrun_evt = w_complete & ~w_load;

    // Holding register, handshake and sticky flags (set beats clear).
    always_comb begin
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid;
        w_overrun_nxt = r_overrun;
        w_frame_nxt   = r_frame_err;
        if (w_load) begin
            w_data_nxt  = w_word;
            w_valid_nxt = 1'b1;
        end else if (w_drain) begin
            w_valid_nxt = 1'b0;
        end else begin
            w_valid_nxt = r_valid;
        end
        if (w_overrun_evt) begin
            w_overrun_nxt = 1'b1;
        end else if (bus.clr_err) begin
            w_overrun_nxt = 1'b0;
        end else begin
            w_overrun_nxt = r_overrun;
        end
        if (w_frame_evt) begin
            w_frame_nxt = 1'b1;
        end else if (bus.clr_err) begin
            w_frame_nxt = 1'b0;
        end else begin
            w_frame_nxt = r_frame_err;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_shreg     <= {WIDTH{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_data      <= {WIDTH{1'b0}};
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_busy      <= (w_state_nxt == ST_RECV);
            r_overrun   <= w_overrun_nxt;
            r_frame_err <= w_frame_nxt;
        end
    end

    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.busy       = r_busy;
    assign bus.overrun    = r_overrun;
    assign bus.frame_err  = r_frame_err;

endmodule
